touch_led_ctrl: RTL and testbench

Touch-key LED mode controller. Debounces the raw touch input, classifies presses as short or long, and sequences a 4-LED bank through OFF / STATIC / FLOW / BLINK display modes. Sits between the touch pad pin and the board LEDs. It replaces a single-edge toggle with a mode state machine and a step timer.

---
 rtl/touch_led_ctrl.sv | 135 +++++++++++++
 tb/tb_touch_led_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/touch_led_ctrl.sv
// Touch-key LED mode controller: synchronizes and debounces the touch pad,
// classifies presses as short/long and sequences a 4-LED bank through display modes.
module touch_led_ctrl #(
    parameter int unsigned DEB_CYCLES  = 500_000,
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int unsigned STEP_CYCLES = 12_500_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       touch_key,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       press_short,
    output logic       press_long
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int unsigned STEP_W = $clog2(STEP_CYCLES);
    localparam int unsigned LED_W  = 4;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_FLOW   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    logic              key_meta_q, key_meta_d;
    logic              key_s_q, key_s_d;
    logic              key_db_q, key_db_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              press_short_q, press_short_d;
    logic              press_long_q, press_long_d;
    mode_e             mode_q, mode_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta_q    <= 1'b0;
            key_s_q       <= 1'b0;
            key_db_q      <= 1'b0;
            deb_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            press_short_q <= 1'b0;
            press_long_q  <= 1'b0;
            mode_q        <= MODE_OFF;
            led_q         <= '0;
            step_cnt_q    <= '0;
        end else begin
            key_meta_q    <= key_meta_d;
            key_s_q       <= key_s_d;
            key_db_q      <= key_db_d;
            deb_cnt_q     <= deb_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            press_short_q <= press_short_d;
            press_long_q  <= press_long_d;
            mode_q        <= mode_d;
            led_q         <= led_d;
            step_cnt_q    <= step_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        key_meta_d    = touch_key;
        key_s_d       = key_meta_q;
        key_db_d      = key_db_q;
        deb_cnt_d     = '0;
        hold_cnt_d    = '0;
        press_short_d = 1'b0;
        press_long_d  = 1'b0;
        mode_d        = mode_q;
        led_d         = led_q;
        step_cnt_d    = '0;

        if (key_s_q != key_db_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                key_db_d = key_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end

        // Hold counter saturates, so a saturated count at release marks a long press
        if (key_db_q) begin
            if (hold_cnt_q != HOLD_W'(LONG_CYCLES)) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
            press_long_d = (hold_cnt_q == HOLD_W'(LONG_CYCLES - 1));
        end else begin
            press_short_d = (hold_cnt_q != '0) && (hold_cnt_q != HOLD_W'(LONG_CYCLES));
        end

        if (press_long_q) begin
            mode_d = MODE_OFF;
        end else if (press_short_q) begin
            case (mode_q)
                MODE_OFF:    mode_d = MODE_STATIC;
                MODE_STATIC: mode_d = MODE_FLOW;
                MODE_FLOW:   mode_d = MODE_BLINK;
                MODE_BLINK:  mode_d = MODE_STATIC;
                default:     mode_d = MODE_OFF;
            endcase
        end

        // Entry pattern on mode change, otherwise step the pattern in FLOW/BLINK
        if (mode_d != mode_q) begin
            case (mode_d)
                MODE_OFF:    led_d = 4'b0000;
                MODE_STATIC: led_d = 4'b1111;
                MODE_FLOW:   led_d = 4'b0001;
                MODE_BLINK:  led_d = 4'b1111;
                default:     led_d = 4'b0000;
            endcase
        end else if ((mode_q == MODE_FLOW) || (mode_q == MODE_BLINK)) begin
            if (step_cnt_q == STEP_W'(STEP_CYCLES - 1)) begin
                led_d = (mode_q == MODE_FLOW) ? {led_q[LED_W-2:0], led_q[LED_W-1]} : ~led_q;
            end else begin
                step_cnt_d = step_cnt_q + STEP_W'(1);
            end
        end
    end

    assign led         = led_q;
    assign mode        = mode_q;
    assign press_short = press_short_q;
    assign press_long  = press_long_q;

endmodule

// File: tb/tb_touch_led_ctrl.sv
// Bench for touch_led_ctrl: directed press table, multi-cycle corner sequences and
// random presses, all checked every cycle against an event-level reference model.
module tb_touch_led_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int STEP = 8;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       touch_key = 1'b0;
    logic [3:0] led;
    logic [1:0] mode;
    logic       press_short;
    logic       press_long;

    touch_led_ctrl #(
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG),
        .STEP_CYCLES(STEP)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .touch_key  (touch_key),
        .led        (led),
        .mode       (mode),
        .press_short(press_short),
        .press_long (press_long)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cnt_short = 0;
    int cnt_long  = 0;

    // Reference model: key state history plus rise/fall/entry timestamps
    int m_cyc = 0;
    int m_meta, m_ks, m_db, m_run;
    int m_rise, m_fall;
    int m_mode, m_entry;
    bit m_short, m_long;

    function automatic logic [3:0] model_led();
        int k;
        k = (m_cyc - m_entry) / STEP;
        case (m_mode)
            1:       return 4'b1111;
            2:       return 4'b0001 << (k % 4);
            3:       return ((k % 2) == 1) ? 4'b0000 : 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_meta = 0; m_ks = 0; m_db = 0; m_run = 0;
        m_rise = -1000; m_fall = -1000;
        m_mode = 0; m_entry = m_cyc;
        m_short = 0; m_long = 0;
    endtask

    // Predict state just after the next rising edge, given the key level it samples
    task automatic model_step(input logic tk);
        int c;
        int db_old, ks_old;
        bit n_short, n_long;
        m_cyc++;
        c = m_cyc;
        db_old = m_db;
        ks_old = m_ks;
        if (m_short) begin
            m_mode  = (m_mode == 3) ? 1 : m_mode + 1;
            m_entry = c;
        end else if (m_long) begin
            if (m_mode != 0) m_entry = c;
            m_mode = 0;
        end
        n_long  = (db_old == 1) && (c == m_rise + LONG);
        n_short = (m_fall == c - 1) && (m_fall - m_rise < LONG);
        if (ks_old != db_old) begin
            m_run++;
            if (m_run == DEB) begin
                m_db  = ks_old;
                m_run = 0;
                if (ks_old == 1) m_rise = c;
                else             m_fall = c;
            end
        end else begin
            m_run = 0;
        end
        m_ks    = m_meta;
        m_meta  = int'(tk);
        m_short = n_short;
        m_long  = n_long;
    endtask

    task automatic check_model();
        logic [7:0] exp, act;
        exp = {2'(m_mode), model_led(), m_short, m_long};
        act = {mode, led, press_short, press_long};
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL model cyc=%0d: got mode=%0d led=%b s=%b l=%b, exp mode=%0d led=%b s=%b l=%b",
                     m_cyc, act[7:6], act[5:2], act[1], act[0], exp[7:6], exp[5:2], exp[1], exp[0]);
        end
        cnt_short += int'(press_short);
        cnt_long  += int'(press_long);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, exp %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic tk);
        touch_key = tk;
        model_step(tk);
        @(negedge sys_clk);
        check_model();
    endtask

    typedef struct {
        string      name;
        int         hold;
        int         idle;
        logic [1:0] exp_mode;
        logic [3:0] exp_led;
        int         exp_shorts;
        int         exp_longs;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{"glitch",      3, 10, 2'd0, 4'b0000, 0, 0};
        tbl[1]  = '{"to_static",  10, 10, 2'd1, 4'b1111, 1, 0};
        tbl[2]  = '{"to_flow",    10,  8, 2'd2, 4'b0001, 1, 0};
        tbl[3]  = '{"flow_8",      0,  8, 2'd2, 4'b0010, 0, 0};
        tbl[4]  = '{"flow_16",     0,  8, 2'd2, 4'b0100, 0, 0};
        tbl[5]  = '{"flow_24",     0,  8, 2'd2, 4'b1000, 0, 0};
        tbl[6]  = '{"flow_32",     0,  8, 2'd2, 4'b0001, 0, 0};
        tbl[7]  = '{"to_blink",   10,  8, 2'd3, 4'b1111, 1, 0};
        tbl[8]  = '{"blink_8",     0,  8, 2'd3, 4'b0000, 0, 0};
        tbl[9]  = '{"blink_static",10, 8, 2'd1, 4'b1111, 1, 0};
        tbl[10] = '{"to_flow2",   10,  8, 2'd2, 4'b0001, 1, 0};
        tbl[11] = '{"long_flow",  60, 10, 2'd0, 4'b0000, 0, 1};
        tbl[12] = '{"long_off",   30, 10, 2'd0, 4'b0000, 0, 1};

        // Reset and idle
        repeat (3) @(negedge sys_clk);
        check_val("reset_outputs", int'({mode, led, press_short, press_long}), 0);
        sys_rst_n = 1'b1;
        model_reset();
        cnt_short = 0; cnt_long = 0;
        repeat (50) step(1'b0);
        check_val("idle_pulses", cnt_short + cnt_long, 0);
        check_val("idle_mode", int'(mode), 0);

        // Directed press table
        for (int i = 0; i < 13; i++) begin
            cnt_short = 0; cnt_long = 0;
            for (int j = 0; j < tbl[i].hold; j++) step(1'b1);
            for (int j = 0; j < tbl[i].idle; j++) step(1'b0);
            check_val({tbl[i].name, "_mode"},   int'(mode),  int'(tbl[i].exp_mode));
            check_val({tbl[i].name, "_led"},    int'(led),   int'(tbl[i].exp_led));
            check_val({tbl[i].name, "_shorts"}, cnt_short,   tbl[i].exp_shorts);
            check_val({tbl[i].name, "_longs"},  cnt_long,    tbl[i].exp_longs);
        end

        // Bouncy release counts as one short press
        cnt_short = 0; cnt_long = 0;
        repeat (10) step(1'b1);
        repeat (2) step(1'b0);
        repeat (2) step(1'b1);
        step(1'b0);
        step(1'b1);
        repeat (14) step(1'b0);
        check_val("bounce_shorts", cnt_short, 1);
        check_val("bounce_mode", int'(mode), 1);

        // Into FLOW, then reset mid long-press
        repeat (10) step(1'b1);
        repeat (8) step(1'b0);
        check_val("pre_reset_mode", int'(mode), 2);
        repeat (12) step(1'b1);
        sys_rst_n = 1'b0;
        #1;
        check_val("async_reset", int'({mode, led, press_short, press_long}), 0);
        touch_key = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge sys_clk);
            check_val("in_reset", int'({mode, led, press_short, press_long}), 0);
        end
        sys_rst_n = 1'b1;
        cnt_short = 0; cnt_long = 0;
        repeat (40) step(1'b0);
        check_val("post_reset_pulses", cnt_short + cnt_long, 0);
        check_val("post_reset_mode", int'(mode), 0);

        // Random presses with occasional bounce, checked by the model every cycle
        for (int i = 0; i < 40; i++) begin
            int hold, idle;
            hold = int'($urandom_range(1, 35));
            idle = int'($urandom_range(1, 30));
            for (int j = 0; j < hold; j++) step(($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1);
            for (int j = 0; j < idle; j++) step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end
        repeat (40) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
